flp_sum_stream: RTL and testbench

Parametrised streaming successor to the fixed 10-input FLP adder tree. It sums `N_IN` unsigned inputs per beat through a registered, pipelined adder tree. It accumulates across multiple beats until `in_last`, then normalises the total into an (exp, mant) pseudo-float. The block feeds the denominator path of the pseudo-softmax, with valid/ready handshaking and backpressure.

---
 rtl/flp_sum_pkg.sv | 37 +++
 rtl/flp_normalize.sv | 64 ++++++
 rtl/flp_sum_stream.sv | 171 +++++++++++++++++
 tb/tb_flp_sum_stream.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flp_sum_pkg.sv
// rtl/flp_sum_pkg.sv - shared helpers, result type and parameter checks for flp_sum_stream
package flp_sum_pkg;

    // Default result field widths, matching the default flp_sum_stream build.
    localparam int RES_EXP_W  = 9;
    localparam int RES_MANT_W = 8;

    typedef struct packed {
        logic [RES_EXP_W-1:0]  exp;
        logic [RES_MANT_W-1:0] mant;
        logic                  zero;
        logic                  ovf;
    } flp_res_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Width of one beat's tree sum: each of the clog2 stages adds one bit.
    function automatic int sum_w(input int n_in, input int in_w);
        return in_w + clog2(n_in);
    endfunction

    // The exponent must be able to hold ACC_W, which a rounding carry can reach.
    function automatic bit params_ok(input int n_in, input int in_w, input int acc_w,
                                     input int mant_w, input int exp_w);
        return (n_in >= 2) && (in_w >= 1) && (mant_w >= 1) && (exp_w < 31) &&
               (acc_w >= sum_w(n_in, in_w)) && ((1 << exp_w) > acc_w);
    endfunction

endpackage

// File: rtl/flp_normalize.sv
// rtl/flp_normalize.sv - leading-one normaliser; FLP_SUM_ROUND_EN selects round half-up
module flp_normalize
    import flp_sum_pkg::*;
#(
    parameter int ACC_W  = 16,
    parameter int MANT_W = 8,
    parameter int EXP_W  = 9
) (
    input  logic [ACC_W-1:0]  sum,
    input  logic              ovf,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] mant,
    output logic              zero
);

    logic [EXP_W-1:0]        lead;
    logic [ACC_W+MANT_W-1:0] ext;
    logic [MANT_W-1:0]       mant_t;

    // Leading-one index; the highest set bit wins because it is assigned last.
    always_comb begin
        lead = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (sum[i]) lead = EXP_W'(i);
        end
    end

    // Zero padding below the sum makes short values come out left-aligned with zero fill.
    assign ext    = {sum, {MANT_W{1'b0}}};
    assign mant_t = MANT_W'(ext >> (lead + EXP_W'(1)));

`ifdef FLP_SUM_ROUND_EN
    logic          rnd;
    logic [MANT_W:0] mant_r;
    // ext bit 'lead' is the first bit below the mantissa LSB.
    assign rnd    = 1'(ext >> lead);
    assign mant_r = {1'b0, mant_t} + (MANT_W+1)'(rnd);
`endif

    // Select saturated, zero or normalised result.
    always_comb begin
        exp  = lead;
        mant = mant_t;
        zero = 1'b0;
        if (ovf) begin
            exp  = EXP_W'(ACC_W - 1);
            mant = '1;
        end else if (sum == '0) begin
            exp  = '0;
            mant = '0;
            zero = 1'b1;
        end else begin
`ifdef FLP_SUM_ROUND_EN
            if (mant_r[MANT_W]) begin
                mant = MANT_W'(1) << (MANT_W - 1);
                exp  = lead + EXP_W'(1);
            end else begin
                mant = mant_r[MANT_W-1:0];
            end
`endif
        end
    end

endmodule

// File: rtl/flp_sum_stream.sv
// rtl/flp_sum_stream.sv - pipelined N_IN-input adder tree, saturating accumulator, normaliser (FLP_SUM_ROUND_EN selects rounding)
module flp_sum_stream
    import flp_sum_pkg::*;
#(
    parameter int N_IN   = 10,
    parameter int IN_W   = 8,
    parameter int ACC_W  = 16,
    parameter int MANT_W = 8,
    parameter int EXP_W  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W-1:0]     exp,
    output logic [MANT_W-1:0]    mant,
    output logic                 zero,
    output logic                 ovf
);

    localparam int LVL = clog2(N_IN);
    localparam int S_W = sum_w(N_IN, IN_W);

    if (!params_ok(N_IN, IN_W, ACC_W, MANT_W, EXP_W)) begin : g_bad_params
        $error("flp_sum_stream: illegal parameter combination");
    end

    logic stall;
    logic beat;

    // A held output stalls the whole pipeline, accumulator included.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst & ~stall;
    assign beat     = in_valid & in_ready;

    // cur[s] feeds tree stage s; tree_q[s] is the registered output of that stage.
    logic [S_W-1:0] cur    [0:LVL-1][0:N_IN-1];
    logic [S_W-1:0] nxt    [0:LVL-1][0:N_IN-1];
    logic [S_W-1:0] tree_q [0:LVL-1][0:N_IN-1];
    logic [LVL-1:0] vld_q;
    logic [LVL-1:0] lst_q;

    // Pairwise add per stage; an odd leftover passes straight through.
    always_comb begin
        for (int s = 0; s < LVL; s++) begin
            for (int i = 0; i < N_IN; i++) begin
                cur[s][i] = '0;
                nxt[s][i] = '0;
            end
        end
        for (int i = 0; i < N_IN; i++) begin
            cur[0][i] = S_W'(in_data[i*IN_W +: IN_W]);
        end
        for (int s = 1; s < LVL; s++) begin
            for (int i = 0; i < N_IN; i++) begin
                cur[s][i] = tree_q[s-1][i];
            end
        end
        for (int s = 0; s < LVL; s++) begin
            for (int i = 0; i < N_IN / 2; i++) begin
                if (2 * i + 1 < ((N_IN + (1 << s) - 1) >> s)) begin
                    nxt[s][i] = cur[s][2*i] + cur[s][2*i+1];
                end
            end
            if ((((N_IN + (1 << s) - 1) >> s) % 2) == 1) begin
                nxt[s][((N_IN + (1 << s) - 1) >> s) / 2] =
                    cur[s][((N_IN + (1 << s) - 1) >> s) - 1];
            end
        end
    end

    // Tree data registers; validity is tracked separately so data needs no reset.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int s = 0; s < LVL; s++) begin
                for (int i = 0; i < N_IN; i++) begin
                    tree_q[s][i] <= nxt[s][i];
                end
            end
        end
    end

    // Valid and last travel alongside the tree data.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (!stall) begin
            vld_q <= (vld_q << 1) | LVL'(beat);
            lst_q <= (lst_q << 1) | LVL'(in_last);
        end
    end

    logic [ACC_W-1:0] acc;
    logic             ovf_r;
    logic [ACC_W:0]   acc_sum;
    logic             ovf_n;
    logic [ACC_W-1:0] acc_n;
    logic [ACC_W-1:0] tot;
    logic             tot_ovf;
    logic             tot_vld;

    assign acc_sum = {1'b0, acc} + (ACC_W+1)'(tree_q[LVL-1][0]);
    assign ovf_n   = ovf_r | acc_sum[ACC_W];
    assign acc_n   = ovf_n ? '1 : acc_sum[ACC_W-1:0];

    // Saturating accumulate; a last beat hands the total on and clears for the next vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            ovf_r   <= 1'b0;
            tot     <= '0;
            tot_ovf <= 1'b0;
            tot_vld <= 1'b0;
        end else if (!stall) begin
            tot_vld <= 1'b0;
            if (vld_q[LVL-1]) begin
                if (lst_q[LVL-1]) begin
                    tot     <= acc_n;
                    tot_ovf <= ovf_n;
                    tot_vld <= 1'b1;
                    acc     <= '0;
                    ovf_r   <= 1'b0;
                end else begin
                    acc   <= acc_n;
                    ovf_r <= ovf_n;
                end
            end
        end
    end

    logic [EXP_W-1:0]  n_exp;
    logic [MANT_W-1:0] n_mant;
    logic              n_zero;

    flp_normalize #(
        .ACC_W  (ACC_W),
        .MANT_W (MANT_W),
        .EXP_W  (EXP_W)
    ) u_norm (
        .sum  (tot),
        .ovf  (tot_ovf),
        .exp  (n_exp),
        .mant (n_mant),
        .zero (n_zero)
    );

    // Output register; holds while the consumer is not ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            exp       <= '0;
            mant      <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else if (!stall) begin
            out_valid <= tot_vld;
            if (tot_vld) begin
                exp  <= n_exp;
                mant <= n_mant;
                zero <= n_zero;
                ovf  <= tot_ovf;
            end
        end
    end

endmodule

// File: tb/tb_flp_sum_stream.sv
// tb/tb_flp_sum_stream.sv - self-checking bench for flp_sum_stream (FLP_SUM_ROUND_EN aware)
module tb_flp_sum_stream;
    import flp_sum_pkg::*;

    localparam int N    = 10;
    localparam int W    = 8;
    localparam int MANT = 8;
    localparam int LAT  = clog2(N) + 2;

    logic         clk;
    logic         rst;
    logic [N*W-1:0] in_data;
    logic         in_valid, in_last, in_ready, out_valid, out_ready;
    logic [8:0]   exp;
    logic [7:0]   mant;
    logic         zero, ovf;

    logic [N*W-1:0] in_data_s;
    logic         in_valid_s, in_last_s, in_ready_s, out_valid_s, out_ready_s;
    logic [8:0]   exp_s;
    logic [7:0]   mant_s;
    logic         zero_s, ovf_s;

    flp_sum_stream #(.N_IN(N), .IN_W(W), .ACC_W(16), .MANT_W(MANT), .EXP_W(9)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .exp(exp), .mant(mant), .zero(zero), .ovf(ovf)
    );

    flp_sum_stream #(.N_IN(N), .IN_W(W), .ACC_W(12), .MANT_W(MANT), .EXP_W(9)) dut_s (
        .clk(clk), .rst(rst), .in_data(in_data_s), .in_valid(in_valid_s), .in_last(in_last_s),
        .in_ready(in_ready_s), .out_valid(out_valid_s), .out_ready(out_ready_s),
        .exp(exp_s), .mant(mant_s), .zero(zero_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    int       n_results = 0;
    flp_res_t exp_q[$];
    flp_res_t last_res;
    longint   cur_sum = 0;
    bit       bp_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: saturate, find leading one by arithmetic, take MANT bits, optionally round.
    function automatic flp_res_t model(input longint s, input int accw);
        flp_res_t r;
        int       e;
        longint   m, rem, sh;
        r = '0;
        if (s >= (64'sd1 <<< accw)) begin
            r.exp  = 9'(accw - 1);
            r.mant = '1;
            r.ovf  = 1'b1;
            return r;
        end
        if (s == 0) begin
            r.zero = 1'b1;
            return r;
        end
        e = 0;
        while ((s >> (e + 1)) != 0) e++;
        if (e >= MANT - 1) begin
            sh  = longint'(e - MANT + 1);
            m   = s >> sh;
            rem = s - (m << sh);
`ifdef FLP_SUM_ROUND_EN
            if (sh > 0 && rem >= (64'sd1 <<< (sh - 1))) m++;
            if (m == (64'sd1 <<< MANT)) begin
                m = 64'sd1 <<< (MANT - 1);
                e++;
            end
`else
            if (rem < 0) m = 0;
`endif
        end else begin
            m = s << (MANT - 1 - e);
        end
        r.exp  = 9'(e);
        r.mant = 8'(m);
        return r;
    endfunction

    function automatic longint beat_sum(input logic [N*W-1:0] d);
        longint t;
        t = 0;
        for (int i = 0; i < N; i++) t += longint'(d[i*W +: W]);
        return t;
    endfunction

    function automatic logic [N*W-1:0] rand_beat();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // Present one beat until accepted; the model sees it only on acceptance.
    task automatic send(input logic [N*W-1:0] d, input bit l);
        bit ok, rdy;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            ok = rdy;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            check("send_accepted", 64'(ok), 1);
        end else begin
            cur_sum += beat_sum(d);
            if (l) begin
                exp_q.push_back(model(cur_sum, 16));
                cur_sum = 0;
            end
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(negedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 0);
    endtask

    // Scoreboard: each handshake is compared with the oldest expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("result_expected", 64'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                flp_res_t e;
                e = exp_q.pop_front();
                check("res_exp", 64'(exp), 64'(e.exp));
                check("res_mant", 64'(mant), 64'(e.mant));
                check("res_zero", 64'(zero), 64'(e.zero));
                check("res_ovf", 64'(ovf), 64'(e.ovf));
            end
            last_res = '{exp: exp, mant: mant, zero: zero, ovf: ovf};
            n_results++;
        end
    end

    // Random backpressure, offset from the stimulus update time.
    always @(posedge clk) begin
        #2;
        if (bp_en) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] b110, b511, bz;
        int lat, n0;
        bit seen, found;
        logic [8:0] e0;
        logic [7:0] m0;
        logic       z0, o0;
        flp_res_t   ref_s;

        rst = 1'b1;
        in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_data_s = '0; in_valid_s = 1'b0; in_last_s = 1'b0; out_ready_s = 1'b1;
        for (int i = 0; i < N; i++) b110[i*W +: W] = 8'(i + 1);
        b511 = '0;
        b511[7:0] = 8'hFF; b511[15:8] = 8'hFF; b511[23:16] = 8'h01;
        bz = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_exp", 64'(exp), 0);
        check("rst_mant", 64'(mant), 0);
        check("rst_zero", 64'(zero), 0);
        check("rst_ovf", 64'(ovf), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 1);
        @(posedge clk); #1;

        // Single beat 1..10 and its latency.
        send(b110, 1'b1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin lat = k; break; end
        end
        check("latency", 64'(lat), 64'(LAT));
        check("t1_exp", 64'(exp), 5);
        check("t1_mant", 64'(mant), 64'h DC);
        check("t1_zero", 64'(zero), 0);
        check("t1_ovf", 64'(ovf), 0);
        @(posedge clk); #1;
        drain();

        // Two-beat vector: first beat alone must not produce output.
        n0 = n_results;
        send(b110, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("nonlast_no_output", 64'(seen), 0);
        @(posedge clk); #1;
        send(b110, 1'b1);
        drain();
        check("t2_count", 64'(n_results - n0), 1);
        check("t2_exp", 64'(last_res.exp), 6);
        check("t2_mant", 64'(last_res.mant), 64'h DC);

        // Sum 511: truncation vs rounding.
        send(b511, 1'b1);
        drain();
`ifdef FLP_SUM_ROUND_EN
        check("t3_exp", 64'(last_res.exp), 9);
        check("t3_mant", 64'(last_res.mant), 64'h80);
`else
        check("t3_exp", 64'(last_res.exp), 8);
        check("t3_mant", 64'(last_res.mant), 64'hFF);
`endif

        // Backpressure hold for 5 cycles.
        n0 = n_results;
        out_ready = 1'b0;
        send(rand_beat(), 1'b1);
        send(rand_beat(), 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin found = 1'b1; break; end
        end
        check("stall_result_found", 64'(found), 1);
        e0 = exp; m0 = mant; z0 = zero; o0 = ovf;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("stall_out_valid", 64'(out_valid), 1);
            check("stall_exp", 64'(exp), 64'(e0));
            check("stall_mant", 64'(mant), 64'(m0));
            check("stall_flags", 64'({zero, ovf}), 64'({z0, o0}));
            check("stall_in_ready", 64'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        check("stall_count", 64'(n_results - n0), 2);

        // Random multi-beat vectors under random backpressure.
        n0 = n_results;
        bp_en = 1'b1;
        for (int v = 0; v < 15; v++) begin
            int nb;
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) send(rand_beat(), b == nb - 1);
        end
        bp_en = 1'b0;
        out_ready = 1'b1;
        drain();
        check("rand_count", 64'(n_results - n0), 15);

        // Reset mid-vector discards the partial vector.
        n0 = n_results;
        send(b110, 1'b0);
        rst = 1'b1;
        cur_sum = 0;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(b110, 1'b1);
        drain();
        check("midrst_count", 64'(n_results - n0), 1);
        check("midrst_exp", 64'(last_res.exp), 5);
        check("midrst_mant", 64'(last_res.mant), 64'h DC);

        // ACC_W = 12 instance: saturation, then a clean all-zero vector.
        in_valid_s = 1'b1;
        in_data_s  = '1;
        for (int b = 0; b < 3; b++) begin
            in_last_s = (b == 2);
            @(negedge clk);
            check("small_in_ready", 64'(in_ready_s), 1);
            @(posedge clk); #1;
        end
        in_valid_s = 1'b0;
        in_last_s  = 1'b0;
        ref_s = model(3 * beat_sum('1), 12);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid_s) begin found = 1'b1; break; end
        end
        check("small_ovf_found", 64'(found), 1);
        check("small_ovf", 64'(ovf_s), 64'(ref_s.ovf));
        check("small_ovf_exp", 64'(exp_s), 64'(ref_s.exp));
        check("small_ovf_mant", 64'(mant_s), 64'(ref_s.mant));
        check("small_ovf_zero", 64'(zero_s), 64'(ref_s.zero));
        @(posedge clk); #1;
        in_data_s  = bz;
        in_valid_s = 1'b1;
        in_last_s  = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        in_last_s  = 1'b0;
        ref_s = model(0, 12);
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid_s) begin found = 1'b1; break; end
        end
        check("small_zero_found", 64'(found), 1);
        check("small_zero", 64'(zero_s), 64'(ref_s.zero));
        check("small_zero_exp", 64'(exp_s), 64'(ref_s.exp));
        check("small_zero_mant", 64'(mant_s), 64'(ref_s.mant));
        check("small_zero_ovf", 64'(ovf_s), 64'(ref_s.ovf));
        @(posedge clk); #1;

        repeat (10) @(posedge clk);
        #1;
        check("final_queue_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
